// File: rtl/alu_pkg.sv
// Shared constants for the Y86-64 execute-stage ALU: function codes and condition-code layout.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between the decode side, the ALU and the memory/writeback side.
interface alu_exec_unit_if #(parameter int W = 64);

    logic         in_valid;
    logic         in_ready;
    logic [3:0]   ifun;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         set_cc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_err;
    logic [2:0]   cc;

    modport master (
        output in_valid, ifun, a, b, set_cc, out_ready,
        input  in_ready, out_valid, out_result, out_err, cc
    );

    modport slave (
        input  in_valid, ifun, a, b, set_cc, out_ready,
        output in_ready, out_valid, out_result, out_err, cc
    );

endinterface

// File: rtl/alu_fifo2.sv
// Two-entry result FIFO with asynchronous active-high reset; head data is always presented.
module alu_fifo2 #(
    parameter int DW = 65
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [1:0]    count
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic [1:0] count_next;

    // Storage is reset so the head reads zero straight out of reset.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [DW-1:0] data_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    data_reg <= '0;
                else if (push && (wr_ptr_reg == 1'(gi)))
                    data_reg <= push_data;
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10: count_next = (count_reg == EMPTY) ? ONE : FULL;
            2'b01: count_next = (count_reg == FULL) ? ONE : EMPTY;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= EMPTY;
        end else begin
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_next;
        end
    end

    assign head_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
    assign count     = count_reg;

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU: add/sub/and/xor into a two-entry result buffer.
// Define ALU_CC_EN to build the ZF/SF/OF condition-code register; otherwise cc is tied to its reset value.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);

    logic [W-1:0] r_next;
    logic         err_next;
    logic         push;
    logic         pop;
    logic [W:0]   head_data;
    logic [1:0]   count;

    always_comb begin
        r_next   = '0;
        err_next = 1'b0;
        case (bus.ifun)
            ALU_ADD: r_next = bus.b + bus.a;
            ALU_SUB: r_next = bus.b - bus.a;
            ALU_AND: r_next = bus.b & bus.a;
            ALU_XOR: r_next = bus.b ^ bus.a;
            default: err_next = 1'b1;
        endcase
    end

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    alu_fifo2 #(.DW(W + 1)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({r_next, err_next}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    // Ready depends only on stored occupancy, never on out_ready.
    assign bus.in_ready   = (count != 2'd2);
    assign bus.out_valid  = (count != 2'd0);
    assign bus.out_result = head_data[W:1];
    assign bus.out_err    = head_data[0];

`ifdef ALU_CC_EN
    logic [2:0] flags_next;
    logic [2:0] cc_reg;

    always_comb begin
        flags_next        = '0;
        flags_next[CC_ZF] = (r_next == '0);
        flags_next[CC_SF] = r_next[W-1];
        case (bus.ifun)
            ALU_ADD: flags_next[CC_OF] = (bus.a[W-1] == bus.b[W-1]) && (r_next[W-1] != bus.a[W-1]);
            ALU_SUB: flags_next[CC_OF] = (bus.a[W-1] != bus.b[W-1]) && (r_next[W-1] != bus.b[W-1]);
            default: flags_next[CC_OF] = 1'b0;
        endcase
    end

    // Invalid function codes never disturb the flags, even with set_cc high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cc_reg <= CC_RESET;
        else if (push && bus.set_cc && !err_next)
            cc_reg <= flags_next;
    end

    assign bus.cc = cc_reg;
`else
    logic unused_set_cc;
    assign unused_set_cc = bus.set_cc;
    assign bus.cc        = CC_RESET;
`endif

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execute-stage ALU for the Y86-64 pipeline. It accepts OPq operand pairs through a valid/ready handshake and computes add, sub, and, or xor. Results go into a two-entry output buffer, and the unit maintains the ZF/SF/OF condition-code register. It consumes operands exactly as the ALU benches drive them and presents results to the memory/writeback side under back-pressure.

## Interface
Parameters:
- W, 64, datapath width in bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  an operand pair is presented.
- in_ready  out  1  unit can accept this cycle.
- ifun  in  4  function code: 0 add, 1 sub, 2 and, 3 xor; other values are invalid.
- a  in  W  valA.
- b  in  W  valB.
- set_cc  in  1  update the condition codes from this operation.
- out_valid  out  1  buffer head holds a result.
- out_ready  in  1  consumer takes the head this cycle.
- out_result  out  W  valE at the buffer head.
- out_err  out  1  head entry came from an invalid ifun.
- cc  out  3  {ZF, SF, OF}.

## Operation
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- Arithmetic, wrapping modulo 2^W with no carry out:
  - add: r = b + a.
  - sub: r = b − a.
  - and: r = b & a.
  - xor: r = b ^ a.
- Invalid ifun: r = 0, err = 1, and the CC register is not updated even if set_cc is high.
- Flags from r:
  - ZF = (r == 0).
  - SF = r[W-1].
  - OF for add = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]).
  - OF for sub = (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]).
  - OF for and/xor = 0.
- CC register loads on the accept edge when set_cc = 1 and ifun is valid.
- Output buffer: two-entry FIFO of {r, err}. Count states are EMPTY(0), ONE(1) and FULL(2).
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push and pop → stays ONE, new entry becomes the head.
  - FULL: pop → ONE; no push is possible.
- in_ready = (count != 2). It is registered-state-derived and has no combinational path from out_ready.
- out_valid = (count != 0). out_result and out_err always show the head entry.
- Order is strictly FIFO. Entries are never dropped or duplicated.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, out_result = 0, out_err = 0.
  - cc = {ZF = 1, SF = 0, OF = 0}.
  - FIFO pointers and count = 0.
- Latency: an operation accepted at edge N is visible on out_* after edge N when the buffer was empty. Otherwise it follows the entries ahead of it.
- cc reflects an accepted set_cc operation after its accept edge, independent of when that result is popped.
- Throughput: one operation per cycle while the consumer holds out_ready high.
- FULL with out_ready = 1: pop happens this edge, and in_ready rises the following cycle.
- Reset asserted mid-operation: all buffered results are discarded immediately (asynchronous) and cc returns to its reset value. No output handshake completes while rst is high.
- Handshake rules: the producer holds a/b/ifun/set_cc stable while in_valid && !in_ready. The head stays stable while out_valid && !out_ready.

## Configuration
- ALU_CC_EN
  - Defined: CC register and flag logic are present as described.
  - Undefined: no flag logic and no CC register. cc is tied to 3'b100 (the reset value). set_cc is ignored. The datapath, FIFO and out_err are unchanged.

## Structure
- Shared package alu_pkg holds:
  - ifun constants ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_XOR = 4'h3.
  - CC bit indices CC_ZF = 2, CC_SF = 1, CC_OF = 0.
  - CC reset constant CC_RESET = 3'b100.
- One sub-module, alu_fifo2: parameterised-width two-entry FIFO with push/pop/count, asynchronous active-high reset. The top level contains the combinational ALU, flag logic and CC register, and instantiates alu_fifo2 with width W+1.

## Test plan
- Reset then idle: rst pulse mid-cycle → in_ready = 1, out_valid = 0, cc = 3'b100 with no clock edge needed.
- add with overflow: a = b = 64'h4000_0000_0000_0000, set_cc = 1 → out_result = 64'h8000_0000_0000_0000, cc = {0,1,1}. Follow with sub a = 5, b = 5 → result 0, cc = {1,0,0}.
- and/xor with set_cc = 0: a = 64'hF0F0…F0, b = 64'hFFFF…FF → and gives F0F0…F0, then xor gives 0F0F…0F. cc stays unchanged.
- Back-pressure: out_ready = 0, three back-to-back ops → first two accepted and in_ready = 0 on the third. Release out_ready → results popped in order, third accepted one cycle after the first pop.
- Invalid ifun = 4 with set_cc = 1 → out_result = 0, out_err = 1, cc unchanged.
- Reset while FULL → out_valid drops asynchronously. The next op after reset appears alone at the head.
